// File: rtl/region_scan_ctrl_pkg.sv
// Shared types and constants for the region scan controller.
package region_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StScan,
    StPop,
    StExpand
  } scan_state_e;

  // Neighbour slot indices inside nb_addr / nb_valid / push_positions.
  localparam logic [2:0] UPLEFT    = 3'd7;
  localparam logic [2:0] UP        = 3'd6;
  localparam logic [2:0] UPRIGHT   = 3'd5;
  localparam logic [2:0] LEFT      = 3'd4;
  localparam logic [2:0] RIGHT     = 3'd3;
  localparam logic [2:0] DOWNLEFT  = 3'd2;
  localparam logic [2:0] DOWN      = 3'd1;
  localparam logic [2:0] DOWNRIGHT = 3'd0;

  // One-hot strobe for a slot index.
  function automatic logic [7:0] slot_onehot(input logic [2:0] k);
    logic [7:0] oh;
    oh    = '0;
    oh[k] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/region_lifo.sv
// Pixel-address LIFO: registered push/pop, combinational top-of-stack read.
// A push while full is silently dropped; the caller tracks overflow.
module region_lifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] top
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CntW-1:0]  count_q, count_d;
  logic [IdxW-1:0]  wr_idx, top_idx;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign wr_idx  = count_q[IdxW-1:0];
  assign top_idx = IdxW'(count_q - 1'b1);
  assign top     = empty ? '0 : mem[top_idx];

  // Occupancy next-state; push and pop are never requested together.
  always_comb begin
    count_d = count_q;
    if (push && !full) begin
      count_d = count_q + 1'b1;
    end else if (pop && !empty) begin
      count_d = count_q - 1'b1;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= data_in;
    end
  end

endmodule

// File: rtl/region_scan_ctrl.sv
// Connected-region labelling controller: raster-scans an M x N image for
// unvisited seeds and flood-fills each region through an address LIFO,
// examining the eight neighbours of each popped pixel one slot per cycle.
module region_scan_ctrl
  import region_scan_ctrl_pkg::*;
#(
  parameter int unsigned M           = 16,
  parameter int unsigned N           = 16,
  parameter int unsigned ADDR_WIDTH  = $clog2(M * N),
  parameter int unsigned STACK_DEPTH = M * N
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    clear,
  output logic                    new_pixel,
  output logic [ADDR_WIDTH-1:0]   center_addr,
  output logic [8*ADDR_WIDTH-1:0] nb_addr,
  output logic [7:0]              nb_valid,
  output logic [7:0]              push_positions,
  input  logic [7:0]              iterated_idx,
  input  logic [7:0]              nb_member,
  output logic                    region_start,
  output logic                    region_end,
  output logic [ADDR_WIDTH:0]     region_count,
  output logic                    overflow
);

  localparam int unsigned ColW = $clog2(N);
  localparam int unsigned RowW = ADDR_WIDTH - ColW;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(M * N - 1);
  localparam logic [ADDR_WIDTH-1:0] RowStep  = ADDR_WIDTH'(N);

  scan_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]   scan_q, scan_d;
  logic [ADDR_WIDTH-1:0]   cur_q, cur_d;
  logic [2:0]              k_q, k_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic                    ovf_q, ovf_d;

  logic                    lifo_push, lifo_pop, lifo_full, lifo_empty;
  logic [ADDR_WIDTH-1:0]   lifo_din, lifo_top;

  logic [ADDR_WIDTH-1:0]   slot_addr [8];
  logic [7:0]              slot_valid;

  region_lifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_lifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (lifo_push),
    .pop     (lifo_pop),
    .data_in (lifo_din),
    .full    (lifo_full),
    .empty   (lifo_empty),
    .top     (lifo_top)
  );

  // Neighbour addresses and in-bounds mask around cur_q; out-of-bound slots
  // fall back to the centre address so downstream RAM reads stay in range.
  always_comb begin
    logic [RowW-1:0]       row;
    logic [ColW-1:0]       col;
    logic                  at_top, at_bot, at_left, at_right;
    logic [ADDR_WIDTH-1:0] up_a, down_a;
    logic [ADDR_WIDTH-1:0] raw [8];

    row      = cur_q[ADDR_WIDTH-1:ColW];
    col      = cur_q[ColW-1:0];
    at_top   = (row == '0);
    at_bot   = (row == RowW'(M - 1));
    at_left  = (col == '0);
    at_right = (col == ColW'(N - 1));
    up_a     = cur_q - RowStep;
    down_a   = cur_q + RowStep;

    raw[UPLEFT]    = up_a - 1'b1;
    raw[UP]        = up_a;
    raw[UPRIGHT]   = up_a + 1'b1;
    raw[LEFT]      = cur_q - 1'b1;
    raw[RIGHT]     = cur_q + 1'b1;
    raw[DOWNLEFT]  = down_a - 1'b1;
    raw[DOWN]      = down_a;
    raw[DOWNRIGHT] = down_a + 1'b1;

    slot_valid            = '0;
    slot_valid[UPLEFT]    = !at_top && !at_left;
    slot_valid[UP]        = !at_top;
    slot_valid[UPRIGHT]   = !at_top && !at_right;
    slot_valid[LEFT]      = !at_left;
    slot_valid[RIGHT]     = !at_right;
    slot_valid[DOWNLEFT]  = !at_bot && !at_left;
    slot_valid[DOWN]      = !at_bot;
    slot_valid[DOWNRIGHT] = !at_bot && !at_right;

    for (int k = 0; k < 8; k++) begin
      slot_addr[k] = slot_valid[k] ? raw[k] : cur_q;
    end
  end

  // Drive the neighbour bus: seed address on every slot while scanning.
  always_comb begin
    nb_addr  = '0;
    nb_valid = '0;
    for (int k = 0; k < 8; k++) begin
      if (state_q == StScan) begin
        nb_addr[k*ADDR_WIDTH +: ADDR_WIDTH] = scan_q;
      end else if (state_q == StExpand) begin
        nb_addr[k*ADDR_WIDTH +: ADDR_WIDTH] = slot_addr[k];
      end
    end
    if (state_q == StExpand) begin
      nb_valid = slot_valid;
    end
  end

  // FSM next-state, LIFO requests and pulse outputs.
  always_comb begin
    state_d        = state_q;
    scan_d         = scan_q;
    cur_d          = cur_q;
    k_d            = k_q;
    count_d        = count_q;
    ovf_d          = ovf_q;
    lifo_push      = 1'b0;
    lifo_pop       = 1'b0;
    lifo_din       = '0;
    done           = 1'b0;
    clear          = 1'b0;
    new_pixel      = 1'b0;
    center_addr    = '0;
    push_positions = '0;
    region_start   = 1'b0;
    region_end     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = StClear;
        end
      end
      StClear: begin
        clear   = 1'b1;
        scan_d  = '0;
        state_d = StScan;
      end
      StScan: begin
        center_addr = scan_q;
        if (!iterated_idx[UPLEFT]) begin
          new_pixel    = 1'b1;
          lifo_push    = 1'b1;
          lifo_din     = scan_q;
          region_start = 1'b1;
          count_d      = count_q + 1'b1;
          state_d      = StPop;
        end else if (scan_q == LastAddr) begin
          done    = 1'b1;
          state_d = StIdle;
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end
      StPop: begin
        if (!lifo_empty) begin
          lifo_pop = 1'b1;
          cur_d    = lifo_top;
          k_d      = UPLEFT;
          state_d  = StExpand;
        end else begin
          // Region finished. The last pixel re-enters SCAN, which then sees
          // it visited and issues done on the following cycle.
          region_end = 1'b1;
          if (scan_q != LastAddr) begin
            scan_d = scan_q + 1'b1;
          end
          state_d = StScan;
        end
      end
      StExpand: begin
        center_addr = cur_q;
        if (nb_member[k_q] && slot_valid[k_q] && !iterated_idx[k_q]) begin
          push_positions = slot_onehot(k_q);
          lifo_push      = 1'b1;
          lifo_din       = slot_addr[k_q];
        end
        if (k_q == DOWNRIGHT) begin
          state_d = StPop;
        end else begin
          k_d = k_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A dropped push still reports its strobe; remember that it was lost.
    if (lifo_push && lifo_full) begin
      ovf_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      scan_q  <= '0;
      cur_q   <= '0;
      k_q     <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      scan_q  <= scan_d;
      cur_q   <= cur_d;
      k_q     <= k_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy         = (state_q != StIdle);
  assign region_count = count_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_region_scan_ctrl.sv
// Directed bench for region_scan_ctrl on a 4x4 image with a modelled
// visited RAM; a second instance uses a 2-entry stack to force overflow.
module tb_region_scan_ctrl;

  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default stack depth.
  logic          start_a = 1'b0;
  logic          busy_a, done_a, clear_a, np_a, rs_a, re_a, ovf_a;
  logic [AW-1:0] center_a;
  logic [8*AW-1:0] nb_addr_a;
  logic [7:0]    nb_valid_a, push_a, iter_a;
  logic [7:0]    member_a = 8'h00;
  logic [AW:0]   rcount_a;

  // Instance B: two-entry stack, all neighbours members.
  logic          start_b = 1'b0;
  logic          busy_b, done_b, clear_b, np_b, rs_b, re_b, ovf_b;
  logic [AW-1:0] center_b;
  logic [8*AW-1:0] nb_addr_b;
  logic [7:0]    nb_valid_b, push_b, iter_b;
  logic [AW:0]   rcount_b;

  region_scan_ctrl #(.M(4), .N(4)) dut_a (
    .clk (clk), .reset_n (reset_n), .start (start_a), .busy (busy_a), .done (done_a),
    .clear (clear_a), .new_pixel (np_a), .center_addr (center_a), .nb_addr (nb_addr_a),
    .nb_valid (nb_valid_a), .push_positions (push_a), .iterated_idx (iter_a),
    .nb_member (member_a), .region_start (rs_a), .region_end (re_a),
    .region_count (rcount_a), .overflow (ovf_a)
  );

  region_scan_ctrl #(.M(4), .N(4), .STACK_DEPTH(2)) dut_b (
    .clk (clk), .reset_n (reset_n), .start (start_b), .busy (busy_b), .done (done_b),
    .clear (clear_b), .new_pixel (np_b), .center_addr (center_b), .nb_addr (nb_addr_b),
    .nb_valid (nb_valid_b), .push_positions (push_b), .iterated_idx (iter_b),
    .nb_member (8'hFF), .region_start (rs_b), .region_end (re_b),
    .region_count (rcount_b), .overflow (ovf_b)
  );

  // Visited RAM models.
  logic [15:0] vis_a, vis_b;

  always_ff @(posedge clk) begin
    if (!reset_n || clear_a) begin
      vis_a <= '0;
    end else begin
      if (np_a) vis_a[center_a] <= 1'b1;
      for (int k = 0; k < 8; k++) if (push_a[k]) vis_a[nb_addr_a[k*AW +: AW]] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear_b) begin
      vis_b <= '0;
    end else begin
      if (np_b) vis_b[center_b] <= 1'b1;
      for (int k = 0; k < 8; k++) if (push_b[k]) vis_b[nb_addr_b[k*AW +: AW]] <= 1'b1;
    end
  end

  always_comb begin
    iter_a = '0;
    iter_b = '0;
    for (int k = 0; k < 8; k++) begin
      iter_a[k] = vis_a[nb_addr_a[k*AW +: AW]];
      iter_b[k] = vis_b[nb_addr_b[k*AW +: AW]];
    end
  end

  // Event monitor for instance A (cumulative counters).
  int cyc = 0, n_rs = 0, n_re = 0, n_np = 0, n_push = 0, n_clear = 0, n_done = 0;
  int last_re = 0, last_done = 0, np_addr = -1;
  logic [7:0] nbv_cap [16];

  initial for (int i = 0; i < 16; i++) nbv_cap[i] = 8'h00;

  always @(negedge clk) begin
    cyc    <= cyc + 1;
    n_push <= n_push + $countones(push_a);
    if (rs_a) n_rs <= n_rs + 1;
    if (re_a) begin
      n_re    <= n_re + 1;
      last_re <= cyc;
    end
    if (done_a) begin
      n_done    <= n_done + 1;
      last_done <= cyc;
    end
    if (clear_a) n_clear <= n_clear + 1;
    if (np_a) begin
      n_np    <= n_np + 1;
      np_addr <= int'(center_a);
    end
    if (nb_valid_a != 8'h00) nbv_cap[center_a] <= nb_valid_a;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_start_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    bit seen = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk); #1;
      if (done_a) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, int'(seen), 1);
  endtask

  int b_rs, b_re, b_np, b_push, b_clear, b_done;

  task automatic snap();
    b_rs = n_rs; b_re = n_re; b_np = n_np; b_push = n_push;
    b_clear = n_clear; b_done = n_done;
  endtask

  initial begin
    // Reset state.
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", int'(busy_a), 0);
    check("rst_count", int'(rcount_a), 0);
    check("rst_ovf", int'(ovf_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_nb_addr", int'(nb_addr_a), 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Every pixel is its own region.
    member_a = 8'h00;
    snap();
    pulse_start_a();
    wait_done_a("iso");
    check("iso_rs", n_rs - b_rs, 16);
    check("iso_re", n_re - b_re, 16);
    check("iso_count", int'(rcount_a), 16);
    check("iso_ovf", int'(ovf_a), 0);
    check("iso_done_lag", last_done - last_re, 1);
    check("iso_clear", n_clear - b_clear, 1);
    check("nbv_0", int'(nbv_cap[0]), 8'h0B);
    check("nbv_15", int'(nbv_cap[15]), 8'hD0);
    check("nbv_5", int'(nbv_cap[5]), 8'hFF);
    check("nbv_3", int'(nbv_cap[3]), 8'h16);
    @(negedge clk); #1;
    check("iso_done_pulse", int'(done_a), 0);
    check("iso_idle", int'(busy_a), 0);
    check("iso_done_cnt", n_done - b_done, 1);

    // One region covering the whole image.
    member_a = 8'hFF;
    snap();
    pulse_start_a();
    wait_done_a("full");
    check("full_count", int'(rcount_a), 1);
    check("full_np", n_np - b_np, 1);
    check("full_np_addr", np_addr, 0);
    check("full_push", n_push - b_push, 15);
    check("full_ovf", int'(ovf_a), 0);

    // Small stack overflows but the pass still completes.
    begin
      bit seen = 1'b0;
      @(posedge clk); #1 start_b = 1'b1;
      @(posedge clk); #1 start_b = 1'b0;
      for (int c = 0; c < 1000; c++) begin
        @(negedge clk); #1;
        if (done_b) begin
          seen = 1'b1;
          break;
        end
      end
      check("ovf_done_seen", int'(seen), 1);
      check("ovf_flag", int'(ovf_b), 1);
      @(negedge clk); #1;
      check("ovf_idle", int'(busy_b), 0);
    end

    // Reset in the middle of an expansion.
    member_a = 8'hFF;
    pulse_start_a();
    repeat (4) @(posedge clk);
    #1;
    check("mid_nb_valid", int'(nb_valid_a), 8'h0B);
    check("mid_count", int'(rcount_a), 1);
    reset_n = 1'b0;
    #2;
    check("mid_rst_busy", int'(busy_a), 0);
    check("mid_rst_count", int'(rcount_a), 0);
    check("mid_rst_nbv", int'(nb_valid_a), 0);
    @(posedge clk); #1 reset_n = 1'b1;
    member_a = 8'h00;
    snap();
    pulse_start_a();
    wait_done_a("post_rst");
    check("post_rst_count", int'(rcount_a), 16);
    check("post_rst_re", n_re - b_re, 16);

    // Start pulsed again while busy is ignored.
    snap();
    pulse_start_a();
    repeat (20) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    wait_done_a("restart");
    check("restart_clear", n_clear - b_clear, 1);
    check("restart_rs", n_rs - b_rs, 16);
    check("restart_count", int'(rcount_a), 16);
    @(negedge clk); #1;
    check("restart_done_cnt", n_done - b_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
